// File: rtl/cba_result_stage_if.sv
// Handshake and data bundle between the adder, the result stage and its consumer.
// The slave modport is the stage's view and the master modport is the environment's view.
interface cba_result_stage_if #(
    parameter int NUM_BITS = 32,
    parameter int CNT_BITS = 16
);
    logic                in_valid;
    logic                in_ready;
    logic                a_msb;
    logic                b_msb;
    logic [NUM_BITS-1:0] sum;
    logic                cout;
    logic                sat_en;
    logic                out_valid;
    logic                out_ready;
    logic [NUM_BITS-1:0] out_sum;
    logic                out_cout;
    logic                out_ovf;
    logic                out_zero;
    logic                out_neg;
    logic [CNT_BITS-1:0] ovf_count;
    logic                clr_count;

    modport master (
        output in_valid, a_msb, b_msb, sum, cout, sat_en, out_ready, clr_count,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_neg, ovf_count
    );

    modport slave (
        input  in_valid, a_msb, b_msb, sum, cout, sat_en, out_ready, clr_count,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_neg, ovf_count
    );
endinterface

// File: rtl/cba_result_stage.sv
// Registered result stage behind the carry-bypass adder. It flags signed overflow and can
// saturate the result, buffers entries in a small FIFO, and counts overflow events.
module cba_result_stage #(
    parameter int NUM_BITS = 32,
    parameter int DEPTH    = 2,
    parameter int CNT_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cba_result_stage_if.slave    bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [NUM_BITS-1:0] sum;
        logic                cout;
        logic                ovf;
        logic                zero;
        logic                neg;
    } entry_t;

    // Saturation value: most negative value for negative operands, most positive otherwise.
    function automatic logic [NUM_BITS-1:0] sat_value(input logic neg_operands);
        logic [NUM_BITS-1:0] v;
        v = {1'b0, {(NUM_BITS-1){1'b1}}};
        if (neg_operands) begin
            v = {1'b1, {(NUM_BITS-1){1'b0}}};
        end else begin
            v = {1'b0, {(NUM_BITS-1){1'b1}}};
        end
        return v;
    endfunction

    entry_t              mem_r [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [OCC_W-1:0]    occ_r;
    logic                in_ready_r;
    logic                out_valid_r;
    logic [CNT_BITS-1:0] ovf_count_r;

    logic                ovf_s;
    logic [NUM_BITS-1:0] stored_s;
    entry_t              entry_s;
    entry_t              head_s;
    logic                push_s;
    logic                pop_s;
    logic [OCC_W-1:0]    occ_next_s;

    // Overflow detection, optional saturation and flag derivation for the incoming result.
    always_comb begin
        ovf_s    = (bus.a_msb == bus.b_msb) && (bus.sum[NUM_BITS-1] != bus.a_msb);
        stored_s = bus.sum;
        if (bus.sat_en && ovf_s) begin
            stored_s = sat_value(bus.a_msb);
        end else begin
            stored_s = bus.sum;
        end
        entry_s.sum  = stored_s;
        entry_s.cout = bus.cout;
        entry_s.ovf  = ovf_s;
        entry_s.zero = (stored_s == {NUM_BITS{1'b0}});
        entry_s.neg  = stored_s[NUM_BITS-1];
    end

    // Handshake qualification and next occupancy; a full FIFO refuses a push even while popping.
    always_comb begin
        push_s     = bus.in_valid && in_ready_r;
        pop_s      = out_valid_r && bus.out_ready;
        occ_next_s = occ_r;
        case ({push_s, pop_s})
            2'b10:   occ_next_s = occ_r + OCC_W'(1);
            2'b01:   occ_next_s = occ_r - OCC_W'(1);
            default: occ_next_s = occ_r;
        endcase
    end

    // FIFO storage, pointers and registered full/empty-derived handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            occ_r       <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= entry_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            occ_r       <= occ_next_s;
            in_ready_r  <= (occ_next_s != OCC_W'(DEPTH));
            out_valid_r <= (occ_next_s != OCC_W'(0));
        end
    end

    // Saturating overflow event counter; an overflowing push wins over a clear and yields 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count_r <= '0;
        end else if (push_s && ovf_s) begin
            if (bus.clr_count) begin
                ovf_count_r <= CNT_BITS'(1);
            end else if (ovf_count_r != {CNT_BITS{1'b1}}) begin
                ovf_count_r <= ovf_count_r + CNT_BITS'(1);
            end else begin
                ovf_count_r <= ovf_count_r;
            end
        end else if (bus.clr_count) begin
            ovf_count_r <= '0;
        end else begin
            ovf_count_r <= ovf_count_r;
        end
    end

    assign head_s        = mem_r[rd_ptr_r];
    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_sum   = head_s.sum;
    assign bus.out_cout  = head_s.cout;
    assign bus.out_ovf   = head_s.ovf;
    assign bus.out_zero  = head_s.zero;
    assign bus.out_neg   = head_s.neg;
    assign bus.ovf_count = ovf_count_r;

endmodule

// File: tb/tb_cba_result_stage.sv
// Directed self-checking bench for cba_result_stage with hand-computed expectations.
module tb_cba_result_stage;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    cba_result_stage_if #(.NUM_BITS(32), .CNT_BITS(16)) bus ();

    cba_result_stage #(.NUM_BITS(32), .DEPTH(2), .CNT_BITS(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one result and wait (bounded) until it is accepted; returns #1 after the accept edge.
    task automatic push(input logic a, input logic b, input logic [31:0] s, input logic c, input logic sat);
        int budget;
        bus.a_msb = a; bus.b_msb = b; bus.sum = s; bus.cout = c; bus.sat_en = sat;
        bus.in_valid = 1'b1;
        budget = 20;
        while (!bus.in_ready && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        n_cmp++;
        if (budget == 0) begin
            n_err++; $display("FAIL push_timeout: in_ready=%0b required 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.a_msb = 1'b0; bus.b_msb = 1'b0; bus.sum = 32'd0;
        bus.cout = 1'b0; bus.sat_en = 1'b0; bus.out_ready = 1'b0; bus.clr_count = 1'b0;
        #22;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b need 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b need 1", bus.in_ready); end
        n_cmp++; if (bus.ovf_count !== 16'd0) begin n_err++; $display("FAIL reset_ovf_count: got %0h need 0", bus.ovf_count); end
        n_cmp++; if (bus.out_sum !== 32'd0) begin n_err++; $display("FAIL reset_out_sum: got %0h need 0", bus.out_sum); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL basic_pre_valid: got %0b need 0", bus.out_valid); end
        push(1'b0, 1'b0, 32'd30, 1'b0, 1'b0);
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %0b need 1", bus.out_valid); end
        n_cmp++; if (bus.out_sum !== 32'd30) begin n_err++; $display("FAIL basic_sum: got %0h need 1e", bus.out_sum); end
        n_cmp++; if ({bus.out_ovf, bus.out_zero, bus.out_neg} !== 3'b000) begin n_err++; $display("FAIL basic_flags: got %03b need 000", {bus.out_ovf, bus.out_zero, bus.out_neg}); end
    endtask

    task automatic test_ovf_nosat();
        push(1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b0);
        n_cmp++; if (bus.out_sum !== 32'h8000_0000) begin n_err++; $display("FAIL ovf_nosat_sum: got %0h need 80000000", bus.out_sum); end
        n_cmp++; if ({bus.out_ovf, bus.out_neg} !== 2'b11) begin n_err++; $display("FAIL ovf_nosat_flags: got %02b need 11", {bus.out_ovf, bus.out_neg}); end
        n_cmp++; if (bus.ovf_count !== 16'd1) begin n_err++; $display("FAIL ovf_nosat_count: got %0d need 1", bus.ovf_count); end
    endtask

    task automatic test_ovf_sat_pos();
        push(1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        n_cmp++; if (bus.out_sum !== 32'h7FFF_FFFF) begin n_err++; $display("FAIL sat_pos_sum: got %0h need 7fffffff", bus.out_sum); end
        n_cmp++; if ({bus.out_ovf, bus.out_neg} !== 2'b10) begin n_err++; $display("FAIL sat_pos_flags: got %02b need 10", {bus.out_ovf, bus.out_neg}); end
        n_cmp++; if (bus.ovf_count !== 16'd2) begin n_err++; $display("FAIL sat_pos_count: got %0d need 2", bus.ovf_count); end
    endtask

    task automatic test_ovf_sat_neg();
        push(1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        n_cmp++; if (bus.out_sum !== 32'h8000_0000) begin n_err++; $display("FAIL sat_neg_sum: got %0h need 80000000", bus.out_sum); end
        n_cmp++; if ({bus.out_cout, bus.out_ovf, bus.out_neg} !== 3'b111) begin n_err++; $display("FAIL sat_neg_flags: got %03b need 111", {bus.out_cout, bus.out_ovf, bus.out_neg}); end
        n_cmp++; if (bus.ovf_count !== 16'd3) begin n_err++; $display("FAIL sat_neg_count: got %0d need 3", bus.ovf_count); end
    endtask

    task automatic test_zero();
        push(1'b0, 1'b1, 32'd0, 1'b1, 1'b1);
        n_cmp++; if ({bus.out_zero, bus.out_ovf, bus.out_cout} !== 3'b101) begin n_err++; $display("FAIL zero_flags: got %03b need 101", {bus.out_zero, bus.out_ovf, bus.out_cout}); end
        n_cmp++; if (bus.ovf_count !== 16'd3) begin n_err++; $display("FAIL zero_count: got %0d need 3", bus.ovf_count); end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drained: got %0b need 0", bus.out_valid); end
        bus.out_ready = 1'b0;
        push(1'b0, 1'b0, 32'd1, 1'b0, 1'b0);
        push(1'b0, 1'b0, 32'd2, 1'b0, 1'b0);
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full: in_ready got %0b need 0", bus.in_ready); end
        bus.sum = 32'd3; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if ({bus.in_ready, bus.out_sum} !== {1'b0, 32'd1}) begin n_err++; $display("FAIL bp_hold: in_ready=%0b sum=%0h need 0/1", bus.in_ready, bus.out_sum); end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if ({bus.in_ready, bus.out_sum} !== {1'b1, 32'd2}) begin n_err++; $display("FAIL bp_pop1: in_ready=%0b sum=%0h need 1/2", bus.in_ready, bus.out_sum); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_cmp++; if ({bus.out_valid, bus.out_sum} !== {1'b1, 32'd3}) begin n_err++; $display("FAIL bp_pop2: valid=%0b sum=%0h need 1/3", bus.out_valid, bus.out_sum); end
        @(posedge clk); #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %0b need 0", bus.out_valid); end
    endtask

    task automatic test_mid_reset();
        bus.out_ready = 1'b0;
        push(1'b0, 1'b0, 32'd5, 1'b0, 1'b0);
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL mr_filled: got %0b need 1", bus.out_valid); end
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin n_err++; $display("FAIL mr_handshake: got %02b need 01", {bus.out_valid, bus.in_ready}); end
        n_cmp++; if (bus.ovf_count !== 16'd0) begin n_err++; $display("FAIL mr_count: got %0d need 0", bus.ovf_count); end
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_count_saturate();
        bus.a_msb = 1'b0; bus.b_msb = 1'b0; bus.sum = 32'h8000_0000; bus.sat_en = 1'b0;
        bus.out_ready = 1'b1; bus.in_valid = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        n_cmp++; if (bus.ovf_count !== 16'hFFFF) begin n_err++; $display("FAIL cnt_full: got %0h need ffff", bus.ovf_count); end
        @(posedge clk); #1;
        n_cmp++; if (bus.ovf_count !== 16'hFFFF) begin n_err++; $display("FAIL cnt_hold: got %0h need ffff", bus.ovf_count); end
        bus.clr_count = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (bus.ovf_count !== 16'd1) begin n_err++; $display("FAIL cnt_clr_push: got %0h need 1", bus.ovf_count); end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (bus.ovf_count !== 16'd0) begin n_err++; $display("FAIL cnt_clr: got %0h need 0", bus.ovf_count); end
        bus.clr_count = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_ovf_nosat();
        test_ovf_sat_pos();
        test_ovf_sat_neg();
        test_zero();
        test_back_to_back();
        test_mid_reset();
        test_count_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cba_result_stage.md
Name: cba_result_stage

Overview:
- Registered output stage that sits directly downstream of CarryBypassAdder and consumes its combinational Sum/Cout together with the operand sign bits.
- Computes the signed-overflow flag, optionally saturates the result, and derives zero/negative flags.
- Buffers results in a small FIFO with valid/ready handshakes on both sides.
- Keeps a saturating count of overflow events for debug readout.

Parameters:
NUM_BITS, 32, datapath width; must match the upstream adder.
DEPTH, 2, result FIFO depth; power of two, at least 2.
CNT_BITS, 16, width of the overflow event counter.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  upstream presents a valid adder result this cycle.
in_ready  output  1  stage can accept a result this cycle.
a_msb  input  1  bit NUM_BITS-1 of adder operand A.
b_msb  input  1  bit NUM_BITS-1 of adder operand B.
sum  input  NUM_BITS  adder Sum.
cout  input  1  adder Cout.
sat_en  input  1  sampled on accept; 1 = saturate on signed overflow.
out_valid  output  1  head FIFO entry is valid.
out_ready  input  1  downstream accepts the head entry.
out_sum  output  NUM_BITS  stored result, saturated if applicable.
out_cout  output  1  stored Cout, always unmodified.
out_ovf  output  1  signed overflow occurred for this entry.
out_zero  output  1  out_sum == 0.
out_neg  output  1  out_sum[NUM_BITS-1].
ovf_count  output  CNT_BITS  saturating count of accepted overflowing results.
clr_count  input  1  synchronous clear of ovf_count.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO occupancy = 0; read and write pointers = 0; ovf_count = 0.
  - out_valid = 0; out_sum, out_cout, out_ovf, out_zero and out_neg read 0.
  - in_ready = 1, because it is derived from an empty FIFO.
- Reset asserted mid-operation discards all buffered entries. There is no partial-state recovery.
- Accept: push = in_valid && in_ready. Pop: pop = out_valid && out_ready.
- in_ready = (occupancy != DEPTH). It is purely a function of state, with no combinational path from out_ready.
  - When the FIFO is full, no push occurs even if a pop happens in the same cycle.
- out_valid = (occupancy != 0). The outputs always reflect the head entry, from the registered FIFO head.
- Latency: a result accepted at edge N into an empty FIFO appears on out_* with out_valid = 1 after edge N. There is no same-cycle bypass.
- Simultaneous push and pop when not full and not empty: occupancy is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Overflow detection on accept: ovf = (a_msb == b_msb) && (sum[NUM_BITS-1] != a_msb).
- Stored sum:
  - If sat_en && ovf: stored = a_msb ? {1, NUM_BITS-1 zeros} (most negative) : {0, NUM_BITS-1 ones} (most positive).
  - Otherwise: stored = sum.
- Flags out_zero and out_neg are computed from the stored value, not the raw sum.
- cout is stored unmodified regardless of saturation.
- ovf_count update:
  - On push with ovf = 1, increment; hold at all-ones (no wrap).
  - clr_count = 1 without an overflowing push gives 0 at the next edge.
  - clr_count = 1 coinciding with an overflowing push gives 1.
  - Counting is independent of sat_en.
- An input held while in_ready = 0 is not sampled. Upstream must hold its data until accepted; the stage never drops a result.

Test Plan:
- Reset, then push sum=30 (10+20), a_msb=0, b_msb=0, cout=0, with out_ready=1:
  - out_valid rises 1 cycle after accept.
  - out_sum=30, out_ovf=0, out_zero=0, out_neg=0.
- Push 0x7FFFFFFF+1 (sum=0x80000000, a_msb=0, b_msb=0):
  - sat_en=0: out_sum=0x80000000, out_ovf=1, out_neg=1, ovf_count=1.
  - sat_en=1: out_sum=0x7FFFFFFF, out_neg=0, ovf_count=2.
- Push 0x80000000+0xFFFFFFFF (sum=0x7FFFFFFF, cout=1, a_msb=1, b_msb=1) with sat_en=1:
  - out_sum=0x80000000, out_cout=1, out_ovf=1, out_neg=1.
- Push 14958 + (-14958) (sum=0, cout=1, a_msb=0, b_msb=1):
  - out_zero=1, out_ovf=0, out_cout=1.
- Hold out_ready=0 and push 3 results (DEPTH=2):
  - in_ready drops after the 2nd accept and the 3rd is held.
  - Raising out_ready drains entries in order; the 3rd is accepted on the cycle after the first pop.
- Fill with 1 entry, pulse rst_n low mid-cycle:
  - out_valid=0 and in_ready=1 immediately.
  - ovf_count=0.
  - Preset ovf_count to all-ones via 0xFFFF overflowing pushes; the next overflow push holds it at 0xFFFF.
  - clr_count together with an overflowing push yields 1.
